shared_resource_owner_ctrl: RTL and testbench
=============================================

# shared_resource_owner_ctrl

Ownership controller directly downstream of the round-robin shared-resource arbiter. It latches the one-hot grant, holds the winning client as resource owner across a multi-cycle transaction, and gates the request vector fed back into the arbiter so no second grant issues while the resource is held. Ownership ends on the owner's `done`, on the owner dropping its request, or on a hold timeout.

## Interface
- `N`, 8: number of clients; must match the arbiter.
- `IDW`, `$clog2(N)`: owner index width.
- `MAX_HOLD`, 16: maximum ownership length in cycles; must be ≥ 1.
- `HW`, `$clog2(MAX_HOLD+1)`: hold counter width.

Ports:
- `clk`  in  1  the single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_in`  in  N  raw client requests.
- `grant_in`  in  N  registered one-hot grant from the arbiter.
- `done`  in  N  per-client end-of-transaction; only the owner's bit is honoured.
- `arb_request`  out  N  gated request vector to the arbiter (combinational).
- `owner_valid`  out  1  resource currently owned.
- `owner_onehot`  out  N  owner select; zero when `owner_valid` is 0.
- `owner_id`  out  IDW  binary index of the owner; zero when `owner_valid` is 0.
- `timeout_pulse`  out  1  one-cycle pulse when ownership ends by timeout.
- `err_multi_hot`  out  1  one-cycle pulse when `grant_in` has more than one bit set.

## Operation
The block has three states:

- **IDLE**
  - `arb_request = req_in` when `grant_in == 0`.
  - `arb_request = 0` in any cycle where `grant_in != 0`, which blocks a back-to-back grant.
  - Valid capture: `grant_in` is one-hot and `grant_in & req_in != 0`. On capture, load `owner_onehot`, `owner_id`, clear `hold_cnt`, and go to BUSY.
  - Multi-hot `grant_in`: ignored; `err_multi_hot` asserts for one cycle; state stays IDLE.
  - Stale one-hot grant (granted bit's `req_in` is 0): ignored silently.
- **BUSY**
  - `arb_request = 0`; `grant_in` is ignored; `hold_cnt` increments every cycle.
  - Release if `done[owner_id]` is 1, or `req_in[owner_id]` is 0, or `hold_cnt == MAX_HOLD-1`.
  - Priority: `done` and request-drop take precedence over timeout. If a normal release and the timeout coincide, `timeout_pulse` stays 0.
  - On timeout-only release, `timeout_pulse` is 1 in the following cycle.
  - `done` bits of non-owners are ignored.
  - Any release goes to DRAIN.
- **DRAIN**
  - One cycle; `owner_valid`, `owner_onehot` and `owner_id` are 0; `arb_request = 0`.
  - Flushes the arbiter's registered grant pipeline. Always goes to IDLE next.

Reset:
- State goes to IDLE.
- All registered outputs go to 0: `owner_valid`, `owner_onehot`, `owner_id`, `timeout_pulse`, `err_multi_hot`, and `hold_cnt`.
- Reset asserted during BUSY drops ownership at that edge; no `timeout_pulse` is issued.

## Timing
- All outputs except `arb_request` are registered.
- Capture: valid `grant_in` sampled at edge k → `owner_valid = 1` and owner fields valid from k+1.
- Hold: with no `done` and the request held, `owner_valid` stays high for exactly `MAX_HOLD` cycles.
- Release condition in cycle m:
  - `owner_valid = 0` from m+1 (DRAIN).
  - IDLE from m+2; `arb_request` re-opens in cycle m+2.
- Arbiter round trip: a request re-enabled in cycle m+2 yields `grant_in` at m+3 and `owner_valid` at m+4.
- `timeout_pulse` and `err_multi_hot` are high for exactly one cycle each.

## Structure
- Shared package `shared_resource_pkg` holds:
  - state encoding localparams: `ST_IDLE = 2'd0`, `ST_BUSY = 2'd1`, `ST_DRAIN = 2'd2`;
  - default `N` and `MAX_HOLD`;
  - the `clog2`-based width helpers.
- One sub-module, `onehot_to_bin`:
  - parameter `N`;
  - one-hot in → `IDW`-bit index out, plus a `multi_hot` flag (popcount > 1).
  - Used at capture for both `owner_id` and `err_multi_hot`.

## Test plan
- **Basic ownership:** N=8; `req_in = 8'h04`, `grant_in = 8'h04` at cycle 0; `done[2]` at cycle 5 → `owner_valid` high for cycles 1–5, `owner_id = 2`, `owner_onehot = 8'h04`; DRAIN at cycle 6; `arb_request = 8'h04` again at cycle 7.
- **Timeout:** `MAX_HOLD = 4`; owner 5 holds its request with no `done` → `owner_valid` high for exactly 4 cycles; `timeout_pulse` in the first DRAIN cycle; DRAIN lasts one cycle.
- **done/timeout collision:** `done[owner]` in the same cycle `hold_cnt == MAX_HOLD-1` → release occurs; `timeout_pulse` stays 0.
- **Bad grants:**
  - `grant_in = 8'h0A` in IDLE → `err_multi_hot` for 1 cycle, `owner_valid` stays 0.
  - `grant_in = 8'h01` with `req_in[0] = 0` → no capture, no error.
- **Gating and drops:**
  - During BUSY, `req_in = 8'hFF` and `done = 8'hFF` except the owner's bit → `arb_request = 0` and ownership is held.
  - Owner drops `req_in` → release next edge.
- **Mid-op reset:** `rst` asserted in the third BUSY cycle → all outputs 0 and state IDLE at the next edge; no pulses issued.

Source files
------------

// File: rtl/shared_resource_owner_ctrl_pkg.sv
// rtl/shared_resource_owner_ctrl_pkg.sv - shared constants, state encoding and width helpers
package shared_resource_pkg;

   localparam int DEF_N        = 8;
   localparam int DEF_MAX_HOLD = 16;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_BUSY  = ST_BUSY,
      S_DRAIN = ST_DRAIN
   } state_t;

   // Owner index width; a single client still gets a 1-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Hold counter must be able to reach MAX_HOLD.
   function automatic int hold_width(input int max_hold);
      return $clog2(max_hold + 1);
   endfunction

endpackage

// File: rtl/shared_resource_owner_ctrl_if.sv
// rtl/shared_resource_owner_ctrl_if.sv - client/arbiter bundle seen by the ownership controller
interface shared_resource_owner_ctrl_if
   import shared_resource_pkg::*;
#(
   parameter int N   = DEF_N,
   parameter int IDW = idx_width(N)
) ();

   logic [N-1:0]   req_in;
   logic [N-1:0]   grant_in;
   logic [N-1:0]   done;
   logic [N-1:0]   arb_request;
   logic           owner_valid;
   logic [N-1:0]   owner_onehot;
   logic [IDW-1:0] owner_id;
   logic           timeout_pulse;
   logic           err_multi_hot;

   modport master (
      output req_in, grant_in, done,
      input  arb_request, owner_valid, owner_onehot, owner_id, timeout_pulse, err_multi_hot
   );

   modport slave (
      input  req_in, grant_in, done,
      output arb_request, owner_valid, owner_onehot, owner_id, timeout_pulse, err_multi_hot
   );

endinterface

// File: rtl/shared_resource_owner_ctrl_onehot_to_bin.sv
// rtl/shared_resource_owner_ctrl_onehot_to_bin.sv - one-hot to binary index with multi-hot flag
module onehot_to_bin
   import shared_resource_pkg::*;
#(
   parameter int N   = DEF_N,
   parameter int IDW = idx_width(N)
) (
   input  logic [N-1:0]   onehot,
   output logic [IDW-1:0] idx,
   output logic           multi_hot
);

   localparam int CW = IDW + 1;

   logic [CW-1:0] cnt;

   // OR-reduce set bit positions and count them; idx is only meaningful when exactly one bit is set.
   always_comb begin
      idx = '0;
      cnt = '0;
      for (int i = 0; i < N; i++) begin
         if (onehot[i]) begin
            idx = idx | IDW'(i);
            cnt = cnt + CW'(1);
         end
      end
      multi_hot = (cnt > CW'(1));
   end

endmodule

// File: rtl/shared_resource_owner_ctrl.sv
// rtl/shared_resource_owner_ctrl.sv - holds the arbiter winner as resource owner and gates further requests
module shared_resource_owner_ctrl
   import shared_resource_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int MAX_HOLD = DEF_MAX_HOLD,
   parameter int IDW      = idx_width(N),
   parameter int HW       = hold_width(MAX_HOLD)
) (
   input logic                      clk,
   input logic                      rst,
   shared_resource_owner_ctrl_if.slave bus
);

   state_t         state;
   logic [HW-1:0]  hold_cnt;
   logic           owner_valid;
   logic [N-1:0]   owner_onehot;
   logic [IDW-1:0] owner_id;
   logic           timeout_pulse;
   logic           err_multi_hot;

   logic [IDW-1:0] grant_idx;
   logic           grant_multi;
   logic           grant_valid;
   logic           owner_done;
   logic           owner_dropped;
   logic           normal_release;
   logic           hold_expired;

   onehot_to_bin #(.N(N), .IDW(IDW)) u_grant_dec (
      .onehot    (bus.grant_in),
      .idx       (grant_idx),
      .multi_hot (grant_multi)
   );

   // Only a one-hot grant for a still-requesting client is worth capturing.
   assign grant_valid    = (bus.grant_in != '0) && !grant_multi && ((bus.grant_in & bus.req_in) != '0);
   // Non-owner done bits and requests are masked out by the owner select.
   assign owner_done     = |(bus.done & owner_onehot);
   assign owner_dropped  = ~|(bus.req_in & owner_onehot);
   assign normal_release = owner_done || owner_dropped;
   assign hold_expired   = (hold_cnt == HW'(MAX_HOLD - 1));

   // Requests reach the arbiter only in IDLE with no grant in flight, so no back-to-back grant can issue.
   assign bus.arb_request = ((state == S_IDLE) && (bus.grant_in == '0)) ? bus.req_in : '0;

   assign bus.owner_valid   = owner_valid;
   assign bus.owner_onehot  = owner_onehot;
   assign bus.owner_id      = owner_id;
   assign bus.timeout_pulse = timeout_pulse;
   assign bus.err_multi_hot = err_multi_hot;

   // Ownership FSM: capture in IDLE, count hold in BUSY, one-cycle DRAIN to flush the arbiter grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         hold_cnt      <= '0;
         owner_valid   <= 1'b0;
         owner_onehot  <= '0;
         owner_id      <= '0;
         timeout_pulse <= 1'b0;
         err_multi_hot <= 1'b0;
      end else begin
         timeout_pulse <= 1'b0;
         err_multi_hot <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_multi) begin
                  err_multi_hot <= 1'b1;
               end else if (grant_valid) begin
                  state        <= S_BUSY;
                  hold_cnt     <= '0;
                  owner_valid  <= 1'b1;
                  owner_onehot <= bus.grant_in;
                  owner_id     <= grant_idx;
               end
            end
            S_BUSY: begin
               hold_cnt <= hold_cnt + HW'(1);
               if (normal_release || hold_expired) begin
                  state         <= S_DRAIN;
                  owner_valid   <= 1'b0;
                  owner_onehot  <= '0;
                  owner_id      <= '0;
                  // done/drop win over a coinciding timeout.
                  timeout_pulse <= !normal_release;
               end
            end
            S_DRAIN: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shared_resource_owner_ctrl.sv
// tb/tb_shared_resource_owner_ctrl.sv - randomized and directed bench against a behavioural ownership model
module tb_shared_resource_owner_ctrl;

   localparam int N    = 8;
   localparam int IDW  = 3;
   localparam int MH_A = 16;
   localparam int MH_B = 4;
   localparam int W    = 2 * N + IDW + 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req = '0;
   logic [N-1:0] grant = '0;
   logic [N-1:0] done = '0;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   shared_resource_owner_ctrl_if #(.N(N), .IDW(IDW)) bus_a ();
   shared_resource_owner_ctrl_if #(.N(N), .IDW(IDW)) bus_b ();

   assign bus_a.req_in   = req;
   assign bus_a.grant_in = grant;
   assign bus_a.done     = done;
   assign bus_b.req_in   = req;
   assign bus_b.grant_in = grant;
   assign bus_b.done     = done;

   shared_resource_owner_ctrl #(.N(N), .MAX_HOLD(MH_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   shared_resource_owner_ctrl #(.N(N), .MAX_HOLD(MH_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   always #5 clk = ~clk;

   // owner = -1 when free; age = number of owned cycles including the current one.
   typedef struct {
      int owner;
      int age;
      bit drain;
      bit tp;
      bit err;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.owner = -1;
      m.age   = 0;
      m.drain = 1'b0;
      m.tp    = 1'b0;
      m.err   = 1'b0;
      return m;
   endfunction

   function automatic logic [W-1:0] mdl_out(mdl_t m, logic [N-1:0] r, logic [N-1:0] g);
      logic [N-1:0]   arb;
      logic [N-1:0]   oh;
      logic [IDW-1:0] id;
      logic           v;
      v   = (m.owner >= 0);
      arb = (!v && !m.drain && g == '0) ? r : '0;
      oh  = v ? (N'(1) << m.owner) : '0;
      id  = v ? IDW'(m.owner) : '0;
      return {arb, v, oh, id, m.tp, m.err};
   endfunction

   function automatic mdl_t mdl_next(mdl_t m, int mh, logic [N-1:0] r, logic [N-1:0] g,
                                     logic [N-1:0] d, logic rs);
      mdl_t n;
      bit   normal;
      n     = m;
      n.tp  = 1'b0;
      n.err = 1'b0;
      if (rs) return mdl_reset();
      if (m.drain) begin
         n.drain = 1'b0;
      end else if (m.owner >= 0) begin
         normal = d[m.owner] || !r[m.owner];
         if (normal || m.age == mh) begin
            n.owner = -1;
            n.drain = 1'b1;
            n.tp    = !normal;
         end else begin
            n.age = m.age + 1;
         end
      end else if ($countones(g) > 1) begin
         n.err = 1'b1;
      end else if ($countones(g) == 1 && (g & r) != '0) begin
         for (int i = 0; i < N; i++) if (g[i]) n.owner = i;
         n.age = 1;
      end
      return n;
   endfunction

   // One clock cycle: compare both DUTs to the model mid-cycle, advance the model, return just after the edge.
   task automatic step();
      logic [W-1:0] act_a, act_b, exp_a, exp_b;
      @(negedge clk);
      act_a = {bus_a.arb_request, bus_a.owner_valid, bus_a.owner_onehot, bus_a.owner_id,
               bus_a.timeout_pulse, bus_a.err_multi_hot};
      act_b = {bus_b.arb_request, bus_b.owner_valid, bus_b.owner_onehot, bus_b.owner_id,
               bus_b.timeout_pulse, bus_b.err_multi_hot};
      exp_a = mdl_out(ma, req, grant);
      exp_b = mdl_out(mb, req, grant);
      vectors++;
      if (act_a !== exp_a) begin
         miscompares++;
         $display("FAIL model_a cycle %0d: got %h expected %h", cyc, act_a, exp_a);
      end
      vectors++;
      if (act_b !== exp_b) begin
         miscompares++;
         $display("FAIL model_b cycle %0d: got %h expected %h", cyc, act_b, exp_b);
      end
      ma = mdl_next(ma, MH_A, req, grant, done, rst);
      mb = mdl_next(mb, MH_B, req, grant, done, rst);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic settle();
      req   = '0;
      grant = '0;
      done  = '0;
      repeat (3) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      ma = mdl_reset();
      mb = mdl_reset();
      step();
      vectors++;
      if ({bus_a.owner_valid, bus_a.owner_onehot, bus_a.owner_id, bus_a.timeout_pulse, bus_a.err_multi_hot} !== '0) begin
         miscompares++;
         $display("FAIL reset_a: got valid=%b oh=%h id=%0d", bus_a.owner_valid, bus_a.owner_onehot, bus_a.owner_id);
      end
      vectors++;
      if ({bus_b.owner_valid, bus_b.owner_onehot, bus_b.owner_id, bus_b.timeout_pulse, bus_b.err_multi_hot} !== '0) begin
         miscompares++;
         $display("FAIL reset_b: got valid=%b oh=%h id=%0d", bus_b.owner_valid, bus_b.owner_onehot, bus_b.owner_id);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      req   = 8'h04;
      grant = 8'h04;
      step();
      grant = '0;
      for (int c = 1; c <= 5; c++) begin
         if (c == 5) done = 8'h04;
         vectors++;
         if (bus_a.owner_valid !== 1'b1 || bus_a.owner_id !== 3'd2 || bus_a.owner_onehot !== 8'h04
             || bus_a.arb_request !== 8'h00) begin
            miscompares++;
            $display("FAIL basic_hold c%0d: got valid=%b id=%0d oh=%h arb=%h expected 1/2/04/00",
                     c, bus_a.owner_valid, bus_a.owner_id, bus_a.owner_onehot, bus_a.arb_request);
         end
         step();
      end
      done = '0;
      vectors++;
      if (bus_a.owner_valid !== 1'b0 || bus_a.arb_request !== 8'h00) begin
         miscompares++;
         $display("FAIL basic_drain: got valid=%b arb=%h expected 0/00", bus_a.owner_valid, bus_a.arb_request);
      end
      step();
      vectors++;
      if (bus_a.arb_request !== 8'h04) begin
         miscompares++;
         $display("FAIL basic_reopen: got arb=%h expected 04", bus_a.arb_request);
      end
      step();
      settle();
   endtask

   task automatic test_timeout();
      int hi;
      hi    = 0;
      req   = 8'h20;
      grant = 8'h20;
      step();
      grant = '0;
      for (int c = 1; c <= 6; c++) begin
         if (bus_b.owner_valid === 1'b1) hi++;
         if (c == 5) begin
            vectors++;
            if (bus_b.owner_valid !== 1'b0 || bus_b.timeout_pulse !== 1'b1) begin
               miscompares++;
               $display("FAIL timeout_pulse: got valid=%b tp=%b expected 0/1", bus_b.owner_valid, bus_b.timeout_pulse);
            end
         end
         if (c == 6) begin
            vectors++;
            if (bus_b.timeout_pulse !== 1'b0 || bus_b.arb_request !== 8'h20) begin
               miscompares++;
               $display("FAIL timeout_drain_len: got tp=%b arb=%h expected 0/20", bus_b.timeout_pulse, bus_b.arb_request);
            end
         end
         step();
      end
      vectors++;
      if (hi != MH_B) begin
         miscompares++;
         $display("FAIL timeout_hold_len: got %0d cycles expected %0d", hi, MH_B);
      end
      settle();
   endtask

   task automatic test_collision();
      req   = 8'h08;
      grant = 8'h08;
      step();
      grant = '0;
      for (int c = 1; c <= 4; c++) begin
         if (c == 4) done = 8'h08;
         step();
      end
      done = '0;
      vectors++;
      if (bus_b.owner_valid !== 1'b0 || bus_b.timeout_pulse !== 1'b0) begin
         miscompares++;
         $display("FAIL collision: got valid=%b tp=%b expected 0/0", bus_b.owner_valid, bus_b.timeout_pulse);
      end
      step();
      settle();
   endtask

   task automatic test_bad_grants();
      req   = 8'hFF;
      grant = 8'h0A;
      vectors++;
      if (bus_a.arb_request !== 8'h00) begin
         miscompares++;
         $display("FAIL grant_block: got arb=%h expected 00", bus_a.arb_request);
      end
      step();
      grant = '0;
      vectors++;
      if (bus_a.err_multi_hot !== 1'b1 || bus_a.owner_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL multi_hot: got err=%b valid=%b expected 1/0", bus_a.err_multi_hot, bus_a.owner_valid);
      end
      step();
      vectors++;
      if (bus_a.err_multi_hot !== 1'b0) begin
         miscompares++;
         $display("FAIL multi_hot_len: got err=%b expected 0", bus_a.err_multi_hot);
      end
      req   = 8'hFE;
      grant = 8'h01;
      step();
      grant = '0;
      vectors++;
      if (bus_a.owner_valid !== 1'b0 || bus_a.err_multi_hot !== 1'b0) begin
         miscompares++;
         $display("FAIL stale_grant: got valid=%b err=%b expected 0/0", bus_a.owner_valid, bus_a.err_multi_hot);
      end
      step();
      settle();
   endtask

   task automatic test_gating();
      req   = 8'h02;
      grant = 8'h02;
      step();
      for (int c = 1; c <= 2; c++) begin
         req   = 8'hFF;
         done  = 8'hFD;
         grant = N'(1) << $urandom_range(0, N - 1);
         vectors++;
         if (bus_a.arb_request !== 8'h00 || bus_a.owner_valid !== 1'b1 || bus_a.owner_id !== 3'd1) begin
            miscompares++;
            $display("FAIL gating c%0d: got arb=%h valid=%b id=%0d expected 00/1/1",
                     c, bus_a.arb_request, bus_a.owner_valid, bus_a.owner_id);
         end
         step();
      end
      req   = 8'hFD;
      grant = '0;
      step();
      vectors++;
      if (bus_a.owner_valid !== 1'b0 || bus_a.timeout_pulse !== 1'b0) begin
         miscompares++;
         $display("FAIL req_drop: got valid=%b tp=%b expected 0/0", bus_a.owner_valid, bus_a.timeout_pulse);
      end
      settle();
   endtask

   task automatic test_mid_reset();
      req   = 8'h40;
      grant = 8'h40;
      step();
      grant = '0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      vectors++;
      if ({bus_b.owner_valid, bus_b.owner_onehot, bus_b.owner_id, bus_b.timeout_pulse, bus_b.err_multi_hot} !== '0
          || bus_b.arb_request !== 8'h40) begin
         miscompares++;
         $display("FAIL mid_reset: got valid=%b oh=%h id=%0d tp=%b arb=%h expected 0/00/0/0/40",
                  bus_b.owner_valid, bus_b.owner_onehot, bus_b.owner_id, bus_b.timeout_pulse, bus_b.arb_request);
      end
      req = '0;
      step();
      vectors++;
      if (bus_b.timeout_pulse !== 1'b0 || bus_a.timeout_pulse !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset_pulse: got tp_a=%b tp_b=%b expected 0/0", bus_a.timeout_pulse, bus_b.timeout_pulse);
      end
      settle();
   endtask

   task automatic test_random();
      int r;
      for (int i = 0; i < 1500; i++) begin
         rst  = ($urandom_range(0, 99) == 0);
         req  = N'($urandom) | N'($urandom);
         done = ($urandom_range(0, 7) == 0) ? (N'(1) << $urandom_range(0, N - 1)) : '0;
         r    = $urandom_range(0, 9);
         if (r < 5)      grant = '0;
         else if (r < 9) grant = N'(1) << $urandom_range(0, N - 1);
         else            grant = N'($urandom);
         step();
      end
      rst = 1'b0;
      settle();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_timeout();
      test_collision();
      test_bad_grants();
      test_gating();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
